quadrature_velocity_meter: RTL and testbench

//  Downstream of quadrature_decoder: consumes step_toggle/direction and measures encoder speed two ways.

---
 rtl/quad_pkg.sv | 25 ++
 rtl/quadrature_velocity_meter_if.sv | 27 ++
 rtl/quad_step_detector.sv | 33 +++
 rtl/quadrature_velocity_meter.sv | 176 +++++++++++++++++
 tb/tb_quadrature_velocity_meter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature velocity meter and its
// neighbouring encoder blocks.
package quad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } vm_state_t;

  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_PERIOD_WIDTH = 32;
  localparam int GATE_WIDTH       = 32;

  // Largest value of a signed counter of the given width.
  function automatic longint cnt_max(input int width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  // Most negative value of a signed counter of the given width.
  function automatic longint cnt_min(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/quadrature_velocity_meter_if.sv
// Measurement result bundle from the velocity meter to register/trigger logic.
//
// Handshake: there is no ready. velocity_valid and period_valid are one-clock
// pulses from the same edge that loads the new data; velocity/saturated and
// period then hold until their next pulse, so a consumer may sample either on
// the pulse or later. standstill is a level.
interface quadrature_velocity_meter_if #(
  parameter int CNT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 32
);
  logic signed [CNT_WIDTH-1:0] velocity;
  logic                        velocity_valid;
  logic                        saturated;
  logic [PERIOD_WIDTH-1:0]     period;
  logic                        period_valid;
  logic                        standstill;

  modport master (
    output velocity, velocity_valid, saturated,
    output period, period_valid, standstill
  );

  modport slave (
    input velocity, velocity_valid, saturated,
    input period, period_valid, standstill
  );
endinterface

// File: rtl/quad_step_detector.sv
// Turns the decoder's position LSB into a one-clock step strobe and keeps the
// direction of the previous step for same-direction comparisons.
module quad_step_detector (
  input  logic i_clk,
  input  logic i_aresetn,
  input  logic step_toggle,
  input  logic direction,
  output logic step,
  output logic step_dir,
  output logic last_dir
);

  logic step_d;
  logic dir_d;

  // Track the toggle every clock; remember direction only when a step occurs.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      step_d <= 1'b0;
      dir_d  <= 1'b0;
    end else begin
      step_d <= step_toggle;
      if (step) begin
        dir_d <= direction;
      end
    end
  end

  assign step     = step_toggle ^ step_d;
  assign step_dir = direction;
  assign last_dir = dir_d;

endmodule

// File: rtl/quadrature_velocity_meter.sv
// Encoder speed measurement: signed step count per gate window (fast motion),
// cycle period between same-direction steps (slow motion), and a standstill
// flag after a programmable step timeout.
module quadrature_velocity_meter
  import quad_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
  input  logic                           i_clk,
  input  logic                           i_aresetn,
  input  logic                           enable,
  input  logic                           step_toggle,
  input  logic                           direction,
  input  logic [GATE_WIDTH-1:0]          gate_time,
  input  logic [PERIOD_WIDTH-1:0]        timeout_time,
  quadrature_velocity_meter_if.master    meas,
  output vm_state_t                      state_dbg
);

  localparam logic signed [CNT_WIDTH-1:0] ACC_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));
  localparam logic signed [CNT_WIDTH-1:0] ACC_MIN = CNT_WIDTH'(cnt_min(CNT_WIDTH));
  localparam logic signed [CNT_WIDTH-1:0] ACC_ONE = CNT_WIDTH'(1);

  vm_state_t                   state;
  logic                        step;
  logic                        step_dir;
  logic                        last_dir;

  logic signed [CNT_WIDTH-1:0] acc;
  logic signed [CNT_WIDTH-1:0] acc_nxt;
  logic                        sat_w;
  logic                        sat_nxt;
  logic [GATE_WIDTH-1:0]       gate_len;
  logic [GATE_WIDTH-1:0]       gate_cnt;
  logic [GATE_WIDTH-1:0]       gate_next_len;
  logic                        gate_close;
  logic [PERIOD_WIDTH-1:0]     per_cnt;
  logic [PERIOD_WIDTH-1:0]     per_cnt_inc;
  logic                        tmo_hit;
  logic                        armed;

  logic signed [CNT_WIDTH-1:0] velocity_q;
  logic                        velocity_valid_q;
  logic                        saturated_q;
  logic [PERIOD_WIDTH-1:0]     period_q;
  logic                        period_valid_q;
  logic                        standstill_q;

  quad_step_detector u_step (
    .i_clk       (i_clk),
    .i_aresetn   (i_aresetn),
    .step_toggle (step_toggle),
    .direction   (direction),
    .step        (step),
    .step_dir    (step_dir),
    .last_dir    (last_dir)
  );

  // A gate_time of zero behaves as a one-cycle window.
  assign gate_next_len = (gate_time == '0) ? GATE_WIDTH'(1) : gate_time;
  assign gate_close    = (gate_cnt == gate_len - GATE_WIDTH'(1));
  // per_cnt+1 saturating: doubles as the next counter value and the period result.
  assign per_cnt_inc   = (&per_cnt) ? per_cnt : per_cnt + PERIOD_WIDTH'(1);
  assign tmo_hit       = (timeout_time != '0) &&
                         (per_cnt == timeout_time - PERIOD_WIDTH'(1));

  // Saturating accumulate of this cycle's step; the sticky flag records any clamp.
  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat_w;
    if (step) begin
      if (step_dir) begin
        if (acc == ACC_MAX) sat_nxt = 1'b1;
        else                acc_nxt = acc + ACC_ONE;
      end else begin
        if (acc == ACC_MIN) sat_nxt = 1'b1;
        else                acc_nxt = acc - ACC_ONE;
      end
    end
  end

  // Control FSM with gate window, period timer, standstill and registered outputs.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state            <= IDLE;
      acc              <= '0;
      sat_w            <= 1'b0;
      gate_len         <= GATE_WIDTH'(1);
      gate_cnt         <= '0;
      per_cnt          <= '0;
      armed            <= 1'b0;
      velocity_q       <= '0;
      velocity_valid_q <= 1'b0;
      saturated_q      <= 1'b0;
      period_q         <= '0;
      period_valid_q   <= 1'b0;
      standstill_q     <= 1'b1;
    end else begin
      velocity_valid_q <= 1'b0;
      period_valid_q   <= 1'b0;
      case (state)
        IDLE: begin
          acc          <= '0;
          sat_w        <= 1'b0;
          gate_cnt     <= '0;
          per_cnt      <= '0;
          armed        <= 1'b0;
          standstill_q <= 1'b1;
          if (enable) state <= ARM;
        end
        ARM: begin
          // The step detector already tracks step_toggle, so no stale edge survives.
          acc      <= '0;
          sat_w    <= 1'b0;
          gate_cnt <= '0;
          per_cnt  <= '0;
          armed    <= 1'b0;
          gate_len <= gate_next_len;
          state    <= RUN;
        end
        RUN: begin
          if (!enable) begin
            // Open window is dropped without a valid pulse.
            state        <= IDLE;
            standstill_q <= 1'b1;
            acc          <= '0;
            sat_w        <= 1'b0;
            gate_cnt     <= '0;
            per_cnt      <= '0;
            armed        <= 1'b0;
          end else begin
            if (gate_close) begin
              velocity_q       <= acc_nxt;
              saturated_q      <= sat_nxt;
              velocity_valid_q <= 1'b1;
              acc              <= '0;
              sat_w            <= 1'b0;
              gate_cnt         <= '0;
              gate_len         <= gate_next_len;
            end else begin
              acc      <= acc_nxt;
              sat_w    <= sat_nxt;
              gate_cnt <= gate_cnt + GATE_WIDTH'(1);
            end
            if (step) begin
              if (armed && (step_dir == last_dir)) begin
                period_q       <= per_cnt_inc;
                period_valid_q <= 1'b1;
              end
              per_cnt      <= '0;
              armed        <= 1'b1;
              standstill_q <= 1'b0;
            end else begin
              per_cnt <= per_cnt_inc;
              if (tmo_hit) begin
                standstill_q <= 1'b1;
                armed        <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign meas.velocity       = velocity_q;
  assign meas.velocity_valid = velocity_valid_q;
  assign meas.saturated      = saturated_q;
  assign meas.period         = period_q;
  assign meas.period_valid   = period_valid_q;
  assign meas.standstill     = standstill_q;
  assign state_dbg           = state;

endmodule

// File: tb/tb_quadrature_velocity_meter.sv
// Bench for quadrature_velocity_meter: a 16-bit and a 4-bit counter instance
// share one stimulus stream and are compared every clock against a
// behavioural model, plus directed scenarios with fixed expected values.
module tb_quadrature_velocity_meter;
  import quad_pkg::*;

  // ---------------- clock / reset / inputs ----------------
  logic        i_clk = 1'b0;
  logic        i_aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        step_toggle = 1'b0;
  logic        direction = 1'b0;
  logic [31:0] gate_time = 32'd100;
  logic [31:0] timeout_time = 32'd0;

  always #5 i_clk = ~i_clk;

  quadrature_velocity_meter_if #(.CNT_WIDTH(16), .PERIOD_WIDTH(32)) m16 ();
  quadrature_velocity_meter_if #(.CNT_WIDTH(4),  .PERIOD_WIDTH(32)) m4 ();
  vm_state_t st16;
  vm_state_t st4;

  quadrature_velocity_meter #(.CNT_WIDTH(16), .PERIOD_WIDTH(32)) u_dut (
    .i_clk(i_clk), .i_aresetn(i_aresetn), .enable(enable),
    .step_toggle(step_toggle), .direction(direction),
    .gate_time(gate_time), .timeout_time(timeout_time),
    .meas(m16.master), .state_dbg(st16)
  );

  quadrature_velocity_meter #(.CNT_WIDTH(4), .PERIOD_WIDTH(32)) u_dut4 (
    .i_clk(i_clk), .i_aresetn(i_aresetn), .enable(enable),
    .step_toggle(step_toggle), .direction(direction),
    .gate_time(gate_time), .timeout_time(timeout_time),
    .meas(m4.master), .state_dbg(st4)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pv_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Speed-measurement rules applied once per clock edge with plain integers.
  localparam longint PMAX = 64'hFFFF_FFFF;
  int        wdt [2] = '{16, 4};
  vm_state_t m_mode;
  bit        m_tog_d, m_dir_last, m_armed, m_stand, m_vv, m_pv;
  longint    m_acc [2];
  longint    m_vel [2];
  bit        m_satw [2];
  bit        m_sat [2];
  longint    m_glen, m_gcnt, m_pcnt, m_per;

  task automatic model_reset();
    m_mode = IDLE; m_tog_d = 0; m_dir_last = 0; m_armed = 0; m_stand = 1;
    m_vv = 0; m_pv = 0; m_glen = 1; m_gcnt = 0; m_pcnt = 0; m_per = 0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_vel[k] = 0; m_satw[k] = 0; m_sat[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit     stp;
    longint nv, hi, lo;
    if (!i_aresetn) begin
      model_reset();
      return;
    end
    stp     = (step_toggle != m_tog_d);
    m_tog_d = step_toggle;
    m_vv = 0;
    m_pv = 0;
    case (m_mode)
      IDLE: begin
        m_stand = 1;
        if (enable) m_mode = ARM;
      end
      ARM: begin
        for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_satw[k] = 0; end
        m_gcnt = 0; m_pcnt = 0; m_armed = 0;
        m_glen = (gate_time == 0) ? 1 : longint'(gate_time);
        m_mode = RUN;
      end
      default: begin
        if (!enable) begin
          m_mode  = IDLE;
          m_stand = 1;
        end else begin
          for (int k = 0; k < 2; k++) begin
            if (stp) begin
              hi = (longint'(1) << (wdt[k] - 1)) - 1;
              lo = -(longint'(1) << (wdt[k] - 1));
              nv = m_acc[k] + (direction ? 1 : -1);
              if (nv > hi) begin nv = hi; m_satw[k] = 1; end
              if (nv < lo) begin nv = lo; m_satw[k] = 1; end
              m_acc[k] = nv;
            end
          end
          if (m_gcnt == m_glen - 1) begin
            for (int k = 0; k < 2; k++) begin
              m_vel[k] = m_acc[k]; m_sat[k] = m_satw[k];
              m_acc[k] = 0; m_satw[k] = 0;
            end
            m_vv   = 1;
            m_gcnt = 0;
            m_glen = (gate_time == 0) ? 1 : longint'(gate_time);
          end else begin
            m_gcnt++;
          end
          if (stp) begin
            if (m_armed && (direction == m_dir_last)) begin
              m_per = (m_pcnt + 1 > PMAX) ? PMAX : m_pcnt + 1;
              m_pv  = 1;
            end
            m_pcnt  = 0;
            m_armed = 1;
            m_stand = 0;
          end else begin
            if (timeout_time != 0 && m_pcnt == longint'(timeout_time) - 1) begin
              m_stand = 1;
              m_armed = 0;
            end
            if (m_pcnt < PMAX) m_pcnt++;
          end
        end
      end
    endcase
    if (stp) m_dir_last = direction;
  endtask

  task automatic check_all();
    check("velocity16",  64'(m16.velocity), 64'(m_vel[0]));
    check("vvalid16",    64'(m16.velocity_valid), 64'(m_vv));
    check("saturated16", 64'(m16.saturated), 64'(m_sat[0]));
    check("period16",    64'(m16.period), 64'(m_per));
    check("pvalid16",    64'(m16.period_valid), 64'(m_pv));
    check("standstill16",64'(m16.standstill), 64'(m_stand));
    check("state16",     64'(st16), 64'(m_mode));
    check("velocity4",   64'(m4.velocity), 64'(m_vel[1]));
    check("vvalid4",     64'(m4.velocity_valid), 64'(m_vv));
    check("saturated4",  64'(m4.saturated), 64'(m_sat[1]));
    check("period4",     64'(m4.period), 64'(m_per));
    check("standstill4", 64'(m4.standstill), 64'(m_stand));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
    cyc++;
    if (m16.period_valid) pv_seen++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic toggle_step(input logic d);
    direction   = d;
    step_toggle = ~step_toggle;
    tick();
  endtask

  // Leaves the DUTs in RUN with the first window about to count its first edge.
  task automatic restart(input logic [31:0] g, input logic [31:0] t);
    enable = 1'b0;
    idle(2);
    gate_time    = g;
    timeout_time = t;
    enable       = 1'b1;
    idle(2);
    pv_seen = 0;
  endtask

  task automatic wait_vv(input int k, input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if ((k == 0) ? m16.velocity_valid : m4.velocity_valid) got = 1;
    end
    check("vvalid_wait", 64'(got), 64'd1);
  endtask

  task automatic check_reset_values();
    check("rst_velocity",   64'(m16.velocity), 64'd0);
    check("rst_vvalid",     64'(m16.velocity_valid), 64'd0);
    check("rst_saturated",  64'(m16.saturated), 64'd0);
    check("rst_period",     64'(m16.period), 64'd0);
    check("rst_pvalid",     64'(m16.period_valid), 64'd0);
    check("rst_standstill", 64'(m16.standstill), 64'd1);
    check("rst_state",      64'(st16), 64'(IDLE));
    check("rst_velocity4",  64'(m4.velocity), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  t0;
    bit  got;
    bit  cur_dir;
    int  dens;

    model_reset();
    idle(3);
    check_reset_values();
    i_aresetn = 1'b1;
    idle(2);

    // 1: ten positive steps spaced 7 clocks in a 100-clock window
    restart(32'd100, 32'd0);
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin toggle_step(1'b1); idle(6); end
    wait_vv(0, 100, got);
    check("t1_velocity", 64'(m16.velocity), 64'd10);
    check("t1_saturated", 64'(m16.saturated), 64'd0);
    check("t1_close_cycle", 64'(cyc - t0), 64'd100);

    // 2: five positive then three negative steps, periods around the reversal
    restart(32'd50, 32'd0);
    for (int i = 0; i < 5; i++) begin toggle_step(1'b1); idle(2); end
    toggle_step(1'b0);
    check("t2_reversal_pvalid", 64'(m16.period_valid), 64'd0);
    idle(2);
    toggle_step(1'b0);
    check("t2_same_dir_pvalid", 64'(m16.period_valid), 64'd1);
    check("t2_period", 64'(m16.period), 64'd3);
    idle(2);
    toggle_step(1'b0);
    wait_vv(0, 60, got);
    check("t2_velocity", 64'(m16.velocity), 64'd2);
    check("t2_pvalid_count", 64'(pv_seen), 64'd6);

    // 3: slow steps, timeout to standstill, recovery; 5: step on the timeout cycle
    restart(32'd1000, 32'd5000);
    for (int i = 0; i < 3; i++) begin
      toggle_step(1'b1);
      check("t3_pvalid", 64'(m16.period_valid), (i == 0) ? 64'd0 : 64'd1);
      if (i > 0) check("t3_period", 64'(m16.period), 64'd1000);
      if (i < 2) idle(999);
    end
    idle(4999);
    check("t3_before_timeout", 64'(m16.standstill), 64'd0);
    tick();
    check("t3_timeout", 64'(m16.standstill), 64'd1);
    idle(500);
    toggle_step(1'b1);
    check("t3_wake_standstill", 64'(m16.standstill), 64'd0);
    check("t3_wake_pvalid", 64'(m16.period_valid), 64'd0);
    idle(999);
    toggle_step(1'b1);
    check("t3_second_pvalid", 64'(m16.period_valid), 64'd1);
    check("t3_second_period", 64'(m16.period), 64'd1000);
    idle(4999);
    toggle_step(1'b1);
    check("t5_tmo_standstill", 64'(m16.standstill), 64'd0);
    check("t5_tmo_period", 64'(m16.period), 64'd5000);

    // 4: 4-bit counter clamps at +7, then an empty window clears saturation
    restart(32'd40, 32'd0);
    for (int i = 0; i < 12; i++) begin toggle_step(1'b1); idle(2); end
    wait_vv(1, 20, got);
    check("t4_velocity4", 64'(m4.velocity), 64'd7);
    check("t4_saturated4", 64'(m4.saturated), 64'd1);
    check("t4_velocity16", 64'(m16.velocity), 64'd12);
    wait_vv(1, 45, got);
    check("t4_empty_velocity4", 64'(m4.velocity), 64'd0);
    check("t4_empty_saturated4", 64'(m4.saturated), 64'd0);

    // 5: step on the window-close cycle lands in the closing window
    restart(32'd20, 32'd0);
    idle(19);
    toggle_step(1'b0);
    check("t5_close_vvalid", 64'(m16.velocity_valid), 64'd1);
    check("t5_close_velocity", 64'(m16.velocity), -64'sd1);

    // 6: drop enable mid-window, re-enable with step_toggle high, reset mid-window
    restart(32'd50, 32'd0);
    for (int i = 0; i < 3; i++) begin toggle_step(1'b1); idle(2); end
    enable = 1'b0;
    tick();
    check("t6_drop_vvalid", 64'(m16.velocity_valid), 64'd0);
    check("t6_drop_standstill", 64'(m16.standstill), 64'd1);
    idle(3);
    step_toggle = 1'b1;
    idle(3);
    enable = 1'b1;
    idle(2);
    toggle_step(1'b1);
    idle(2);
    toggle_step(1'b1);
    wait_vv(0, 60, got);
    check("t6_reenable_velocity", 64'(m16.velocity), 64'd2);
    toggle_step(1'b0);
    toggle_step(1'b0);
    #2;
    i_aresetn = 1'b0;
    #1;
    check_reset_values();
    idle(2);
    i_aresetn = 1'b1;
    idle(2);

    // Randomized traffic: varying density, direction runs, enable drops,
    // gate and timeout changes mid-window.
    restart($urandom_range(0, 60), $urandom_range(5, 80));
    cur_dir = 1'b1;
    dens    = 10;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) dens = (c % 1000 == 0) ? $urandom_range(1, 15) : $urandom_range(30, 95);
      if ($urandom_range(0, 99) < dens) begin
        if ($urandom_range(0, 19) == 0) cur_dir = ~cur_dir;
        direction   = cur_dir;
        step_toggle = ~step_toggle;
      end else begin
        direction = 1'($urandom_range(0, 1));
      end
      if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      if ($urandom_range(0, 99) == 0) gate_time = $urandom_range(0, 60);
      if ($urandom_range(0, 199) == 0)
        timeout_time = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(5, 80));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
